// File: rtl/output_arbiter_if.sv
// output_arbiter_if: per-output-port arbitration bus between the input buffer managers and the arbiter.
interface output_arbiter_if #(parameter int N = 4);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    logic [N-1:0]   req;
    logic [2*N-1:0] cmd;
    logic [N-1:0]   empty;
    logic           full;
    logic [N-1:0]   ack;
    logic [W-1:0]   sel;
    logic           valid;
    logic           busy;
    modport master(output req, cmd, empty, full, input ack, sel, valid, busy);
    modport slave(input req, cmd, empty, full, output ack, sel, valid, busy);
endinterface

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin packet arbiter for one switch output; holds the grant from head to tail.
module output_arbiter #(parameter int N = 4) (
    input logic clk,
    input logic rst,
    output_arbiter_if.slave bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [W-1:0] owner, ptr, pick, next_ptr;
    logic xfer, tail;
    // Walk downward so the lowest offset from ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = N - 1; i >= 0; i--)
            if (bus.req[W'((int'(ptr) + i) % N)]) pick = W'((int'(ptr) + i) % N);
    end
    assign xfer = state == GRANT && !bus.empty[owner] && !bus.full;
    assign tail = bus.cmd[{owner, 1'b0} +: 2] == 2'b11;
    assign next_ptr = W'((int'(owner) + 1) % N);
    assign bus.ack = xfer ? N'(1) << owner : '0;
    assign bus.sel = owner;
    assign bus.valid = xfer;
    assign bus.busy = state == GRANT;
    // A packet ends on a transferred tail or when the owner drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr <= '0;
        end else if (state == IDLE) begin
            if (|bus.req) begin
                owner <= pick;
                state <= GRANT;
            end
        end else if ((xfer && tail) || !bus.req[owner]) begin
            state <= IDLE;
            ptr <= next_ptr;
        end
    end
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed cycle-by-cycle stimulus with a scoreboard of expected ack/sel/valid/busy.
module tb_output_arbiter;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string tag;
        logic [7:0] v;
    } exp_t;
    exp_t sb[$];
    output_arbiter_if #(.N(4)) bus();
    output_arbiter #(.N(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [7:0] cm(input int i, input logic [1:0] v);
        logic [7:0] c;
        c = 8'hFF;
        c[2*i +: 2] = v;
        return c;
    endfunction
    task automatic step(input logic r, input logic [3:0] rq, input logic [7:0] c, input logic [3:0] e,
                        input logic f, input logic [3:0] xa, input logic [1:0] xs, input logic xb,
                        input string tag);
        exp_t x;
        rst = r;
        bus.req = rq;
        bus.cmd = c;
        bus.empty = e;
        bus.full = f;
        sb.push_back('{tag, {xa, xs, |xa, xb}});
        @(negedge clk);
        x = sb.pop_front();
        checks++;
        assert ({bus.ack, bus.sel, bus.valid, bus.busy} === x.v) else begin
            errors++;
            $error("FAIL %s: ack/sel/valid/busy got %b_%b_%b_%b want %b_%b_%b_%b", x.tag,
                   bus.ack, bus.sel, bus.valid, bus.busy, x.v[7:4], x.v[3:2], x.v[1], x.v[0]);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.cmd = '0;
        bus.empty = '0;
        bus.full = 1'b0;
        @(posedge clk);
        #1;
        step(1, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_a");
        step(1, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_b");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "rst_release");
        step(0, 4'b1111, cm(0, 2'b10), 4'h0, 0, 4'b0001, 2'd0, 1, "g0_head");
        step(0, 4'b1111, cm(0, 2'b11), 4'h0, 0, 4'b0001, 2'd0, 1, "g0_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "gap0");
        step(0, 4'b1111, cm(1, 2'b10), 4'h0, 0, 4'b0010, 2'd1, 1, "g1_head");
        step(0, 4'b1111, cm(1, 2'b11), 4'h0, 0, 4'b0010, 2'd1, 1, "g1_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd1, 0, "gap1");
        step(0, 4'b1111, cm(2, 2'b10), 4'h0, 0, 4'b0100, 2'd2, 1, "g2_head");
        step(0, 4'b1111, cm(2, 2'b11), 4'h0, 0, 4'b0100, 2'd2, 1, "g2_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd2, 0, "gap2");
        step(0, 4'b1111, cm(3, 2'b10), 4'h0, 0, 4'b1000, 2'd3, 1, "g3_head");
        step(0, 4'b1111, cm(3, 2'b11), 4'h0, 0, 4'b1000, 2'd3, 1, "g3_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd3, 0, "gap3");
        step(0, 4'b1111, cm(0, 2'b10), 4'h0, 0, 4'b0001, 2'd0, 1, "wrap_head");
        step(0, 4'b1111, cm(0, 2'b11), 4'h0, 0, 4'b0001, 2'd0, 1, "wrap_tail");
        step(0, 4'b0000, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "idle_a");
        step(0, 4'b0000, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "idle_hold");
        step(0, 4'b0100, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "req2_t");
        step(0, 4'b0100, cm(2, 2'b10), 4'h0, 0, 4'b0100, 2'd2, 1, "p2_head");
        step(0, 4'b0100, cm(2, 2'b01), 4'h0, 0, 4'b0100, 2'd2, 1, "p2_body");
        step(0, 4'b0100, cm(2, 2'b11), 4'h0, 0, 4'b0100, 2'd2, 1, "p2_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd2, 0, "p2_done");
        step(0, 4'b1111, cm(3, 2'b10), 4'h0, 0, 4'b1000, 2'd3, 1, "ptr3_grant");
        step(1, 4'b1111, cm(3, 2'b01), 4'h0, 0, 4'b1000, 2'd3, 1, "rst_mid");
        step(0, 4'b1001, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "post_rst");
        step(0, 4'b1001, cm(0, 2'b10), 4'h0, 0, 4'b0001, 2'd0, 1, "post_rst_g0");
        step(0, 4'b1001, cm(0, 2'b11), 4'h0, 0, 4'b0001, 2'd0, 1, "post_rst_tail");
        step(0, 4'b0010, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "pre_g1");
        step(0, 4'b0010, cm(1, 2'b10), 4'h0, 0, 4'b0010, 2'd1, 1, "full_head");
        step(0, 4'b0010, cm(1, 2'b11), 4'h0, 1, 4'b0000, 2'd1, 1, "full_a");
        step(0, 4'b0010, cm(1, 2'b11), 4'h0, 1, 4'b0000, 2'd1, 1, "full_b");
        step(0, 4'b0010, cm(1, 2'b11), 4'h0, 0, 4'b0010, 2'd1, 1, "full_tail");
        step(0, 4'b0100, 8'h00, 4'h0, 0, 4'b0000, 2'd1, 0, "full_done");
        step(0, 4'b1111, cm(2, 2'b10), 4'h0, 0, 4'b0100, 2'd2, 1, "empty_head");
        step(0, 4'b1111, cm(2, 2'b01), 4'b0100, 0, 4'b0000, 2'd2, 1, "empty_a");
        step(0, 4'b1111, cm(2, 2'b10), 4'b0100, 0, 4'b0000, 2'd2, 1, "empty_b");
        step(0, 4'b1111, cm(2, 2'b01), 4'b0100, 0, 4'b0000, 2'd2, 1, "empty_c");
        step(0, 4'b1111, cm(2, 2'b10), 4'h0, 0, 4'b0100, 2'd2, 1, "head_mid");
        step(0, 4'b1111, cm(2, 2'b11), 4'h0, 0, 4'b0100, 2'd2, 1, "empty_tail");
        step(0, 4'b1111, 8'h00, 4'h0, 0, 4'b0000, 2'd2, 0, "empty_done");
        step(0, 4'b1111, cm(3, 2'b10), 4'h0, 0, 4'b1000, 2'd3, 1, "abort_head");
        step(0, 4'b0111, cm(3, 2'b01), 4'h0, 0, 4'b1000, 2'd3, 1, "abort_drop");
        step(0, 4'b0111, 8'h00, 4'h0, 0, 4'b0000, 2'd3, 0, "abort_idle");
        step(0, 4'b0111, cm(0, 2'b10), 4'h0, 0, 4'b0001, 2'd0, 1, "abort_next");
        step(0, 4'b0111, cm(0, 2'b11), 4'b0001, 0, 4'b0000, 2'd0, 1, "tail_empty");
        step(0, 4'b0111, cm(0, 2'b11), 4'h0, 0, 4'b0001, 2'd0, 1, "tail_go");
        step(0, 4'b0000, 8'h00, 4'h0, 0, 4'b0000, 2'd0, 0, "final_idle");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter: N, 4, number of switch input ports; one instance per output port.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  N  bit i = input port i's buffer manager holds a packet routed to this output.
REQ-005 cmd  in  2N  command of flit at head of input i, bits [2i+1:2i]; 00 none, 01 body, 10 head, 11 tail.
REQ-006 empty  in  N  bit i = input FIFO i empty.
REQ-007 full  in  1  output link cannot accept a flit this cycle.
REQ-008 ack  out  N  one-hot grant, also read enable for the granted input FIFO; a flit transfers in every cycle ack is nonzero.
REQ-009 sel  out  2  index of owning input, drives crossbar mux.
REQ-010 valid  out  1  equals OR of ack; crossbar output flit valid.
REQ-011 busy  out  1  high while a grant is held (state GRANT).

Function
REQ-012 The block SHALL implement two states: IDLE, GRANT; state, owner[1:0] and round-robin pointer ptr[1:0] are registers.
REQ-013 In IDLE with req != 0, the block SHALL select the first set req bit searching ptr, ptr+1, ... mod N, load owner, and enter GRANT at the next edge.
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE with owner and ptr unchanged.
REQ-015 ack SHALL be combinational from registered state: ack[owner] = (state==GRANT) & ~empty[owner] & ~full; all other bits 0.
REQ-016 sel SHALL equal owner in GRANT and hold its last value in IDLE.
REQ-017 busy SHALL be 1 exactly when state==GRANT.
REQ-018 In GRANT, a cycle with ack nonzero and cmd[owner]==11 SHALL end the packet: next state IDLE, ptr <= owner+1 mod N.
REQ-019 A tail on cmd[owner] in a cycle where ack is 0 (empty or full) SHALL be ignored; the grant is held.
REQ-020 In GRANT, if req[owner] falls without a transferred tail, the block SHALL return to IDLE next edge with ptr <= owner+1 mod N (abort).
REQ-021 Requests from non-owner inputs SHALL be ignored while in GRANT; no preemption.
REQ-022 cmd values on non-owner inputs SHALL NOT affect state.
REQ-023 Latency: req rising in IDLE at cycle t SHALL yield ack earliest at t+1; after tail transfer at t, next grant earliest at t+2.
REQ-024 A head (10) on cmd[owner] during GRANT SHALL NOT restart arbitration.
REQ-025 A packet is at least two flits (head, tail); the first flit transferred under a grant is the head.

Reset
REQ-026 rst high at an edge SHALL force state IDLE, owner 0, ptr 0, regardless of state, including mid-packet.
REQ-027 During and after reset, before any grant: ack 0000, sel 00, valid 0, busy 0.
REQ-028 Reset has priority over req, cmd, empty and full in the same cycle.

Verification
REQ-029 rst high 2 cycles with req=1111 -> ack=0000, sel=0, busy=0 throughout; first grant to input 0 the cycle after rst falls.
REQ-030 req=0100, empty=0, full=0, cmd2 sequence 10,01,11 -> ack=0100, sel=2 for 3 consecutive cycles from t+1; busy falls after tail; ptr=3.
REQ-031 req=1111 held, every packet 2 flits (10,11) -> grant order 0,1,2,3,0 with one idle cycle between packets.
REQ-032 Owner 1 mid-packet, full=1 for 2 cycles with cmd1=11 present -> ack=0000 those cycles, busy=1; tail transfers once full=0, then IDLE.
REQ-033 Owner 2, empty[2]=1 for 3 cycles -> ack=0000, valid=0, busy=1; transfer resumes when empty[2]=0.
REQ-034 rst asserted mid-packet with owner 3 -> next cycle ack=0000, busy=0, ptr=0; with req=1001 after reset, next grant goes to input 0.
